// File: rtl/multicycle_control_if.sv
// Control <-> datapath bundle for the multicycle MIPS core.
// Handshake: mem_read/mem_write stay high while waiting; an access completes in any cycle where mem_ready=1.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal_op;
    logic       mem_error;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_op, mem_error
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal_op, mem_error
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath, with a watchdog
// that aborts memory states stuck waiting on mem_ready.
module multicycle_control #(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [TO_W-1:0] TO_VAL = TO_W'(TIMEOUT);

    logic [3:0]      state_q, state_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic            mem_state;
    logic            wd_abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
        wd_abort  = mem_state && !bus.mem_ready && (wd_q == TO_VAL);
        // The counter only survives a cycle that stays in the same memory state.
        wd_d      = (mem_state && !bus.mem_ready && !wd_abort) ? wd_q + TO_W'(1) : '0;
    end

    always_comb begin
        state_d           = state_q;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        bus.illegal_op    = 1'b0;
        bus.mem_error     = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default: begin
                        state_d        = S_FETCH;
                        bus.illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.iord     = 1'b1;
                bus.mem_read = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWR: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_source     = 2'b01;
                bus.pc_write_cond = 1'b1;
                state_d           = S_FETCH;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_source = 2'b10;
                bus.pc_write  = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (wd_abort) begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
            bus.mem_error = 1'b1;
            state_d       = S_FETCH;
        end

        // Reset holds the datapath quiet even though FETCH would otherwise request memory.
        if (!reset) begin
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.ir_write      = 1'b0;
            bus.reg_write     = 1'b0;
            bus.iord          = 1'b0;
            bus.mem_to_reg    = 1'b0;
            bus.reg_dst       = 1'b0;
            bus.alu_src_a     = 1'b0;
            bus.alu_src_b     = 2'b00;
            bus.alu_op        = 2'b00;
            bus.pc_source     = 2'b00;
            bus.illegal_op    = 1'b0;
            bus.mem_error     = 1'b0;
        end
    end

    assign bus.state = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level model expands each opcode into
// its phase list, producing one expected control word per cycle.
module tb_multicycle_control;
    localparam int TIMEOUT = 15;
    localparam int W       = 22;

    localparam logic [3:0] S_F = 4'd0,  S_D = 4'd1,   S_MA = 4'd2,  S_MRD = 4'd3;
    localparam logic [3:0] S_MWB = 4'd4, S_MWR = 4'd5, S_EX = 4'd6,  S_AWB = 4'd7;
    localparam logic [3:0] S_BR = 4'd8, S_AIX = 4'd9, S_AIW = 4'd10, S_J = 4'd11;

    logic clk = 1'b0;
    logic reset;
    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control_if bus ();

    multicycle_control #(.TIMEOUT(TIMEOUT), .TO_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
    endfunction

    // Expected control word for one cycle spent in phase st.
    function automatic logic [W-1:0] exp_word(input logic [3:0] st, input bit rdy,
                                              input bit abort, input bit ill);
        logic pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            S_F:   begin mr = !abort; irw = rdy; pw = rdy; asb = 2'b01; end
            S_D:   asb = 2'b11;
            S_MA:  begin asa = 1'b1; asb = 2'b10; end
            S_MRD: begin iord = 1'b1; mr = !abort; end
            S_MWB: begin m2r = 1'b1; rw = 1'b1; end
            S_MWR: begin iord = 1'b1; mw = !abort; end
            S_EX:  begin asa = 1'b1; aop = 2'b10; end
            S_AWB: begin rdst = 1'b1; rw = 1'b1; end
            S_BR:  begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pwc = 1'b1; end
            S_AIX: begin asa = 1'b1; asb = 2'b10; end
            S_AIW: rw = 1'b1;
            S_J:   begin psrc = 2'b10; pw = 1'b1; end
            default: ;
        endcase
        return {st, pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill, abort};
    endfunction

    function automatic logic [W-1:0] obs_word();
        return {bus.state, bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source,
                bus.illegal_op, bus.mem_error};
    endfunction

    function automatic int pick_stall(input int mode);
        int r;
        if (mode >= 0) return mode;
        r = $urandom_range(0, 19);
        if (r < 12) return 0;
        if (r < 17) return $urandom_range(1, 4);
        if (r == 17) return TIMEOUT;
        if (r == 18) return TIMEOUT + 1;
        return TIMEOUT - 1;
    endfunction

    // driver tasks
    task automatic rst_cycle();
        @(posedge clk); #1;
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'($urandom_range(0, 1));
        exp_q.push_back('0);
    endtask

    task automatic cycle(input logic [3:0] st, input logic [5:0] op, input bit rdy,
                         input bit abort, input bit ill);
        @(posedge clk); #1;
        reset         = 1'b1;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        bus.zero      = 1'($urandom_range(0, 1));
        exp_q.push_back(exp_word(st, rdy, abort, ill));
    endtask

    // One instruction; stall < 0 means random; cut > 0 stops after that many cycles.
    task automatic run_instr(input logic [5:0] op, input int f_stall, input int m_stall,
                             input int cut);
        logic [3:0] ph[$];
        logic [3:0] st;
        int  fs, n, s;
        bit  stop, refetch, ab;
        ph.push_back(S_F);
        ph.push_back(S_D);
        case (op)
            6'b000000: begin ph.push_back(S_EX);  ph.push_back(S_AWB); end
            6'b100011: begin ph.push_back(S_MA);  ph.push_back(S_MRD); ph.push_back(S_MWB); end
            6'b101011: begin ph.push_back(S_MA);  ph.push_back(S_MWR); end
            6'b000100: ph.push_back(S_BR);
            6'b000010: ph.push_back(S_J);
            6'b001000: begin ph.push_back(S_AIX); ph.push_back(S_AIW); end
            default: ;
        endcase
        fs = f_stall; n = 0; stop = 1'b0;
        do begin
            refetch = 1'b0;
            for (int i = 0; i < ph.size() && !stop && !refetch; i++) begin
                st = ph[i];
                if (st == S_F || st == S_MRD || st == S_MWR) begin
                    s  = (st == S_F) ? pick_stall(fs) : pick_stall(m_stall);
                    ab = 1'b0;
                    for (int w = 0; w <= s && !stop; w++) begin
                        if (w < s) begin
                            ab = (w == TIMEOUT);
                            cycle(st, op, 1'b0, ab, 1'b0);
                        end else begin
                            cycle(st, op, 1'b1, 1'b0, 1'b0);
                        end
                        n++;
                        if (n == cut) stop = 1'b1;
                        if (ab) break;
                    end
                    if (ab) begin
                        if (st == S_F) begin refetch = 1'b1; fs = 0; end
                        else stop = 1'b1;
                    end
                end else begin
                    cycle(st, op, 1'($urandom_range(0, 1)), 1'b0, (st == S_D) && !is_legal(op));
                    n++;
                    if (n == cut) stop = 1'b1;
                end
            end
        end while (refetch && !stop);
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        logic [W-1:0] e, o;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_word();
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL ctl t=%0t: got state=%0d word=%h, expected state=%0d word=%h",
                         $time, o[W-1 -: 4], o, e[W-1 -: 4], e);
            end
        end
    end

    initial begin
        logic [5:0] op;
        int k;
        logic [5:0] legal_ops[6];
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        reset = 1'b0; bus.mem_ready = 1'b1; bus.opcode = '0; bus.zero = 1'b0;

        repeat (3) rst_cycle();
        run_instr(6'b000000, 0, 0, 0);
        run_instr(6'b100011, 0, 3, 0);
        run_instr(6'b000100, 0, 0, 0);
        run_instr(6'b000010, 0, 0, 0);
        run_instr(6'b001000, 0, 0, 0);
        run_instr(6'b101011, 0, 0, 0);
        run_instr(6'b111111, 0, 0, 0);
        run_instr(6'b000000, TIMEOUT + 1, 0, 0);
        run_instr(6'b101011, TIMEOUT, TIMEOUT, 0);
        run_instr(6'b100011, 2, TIMEOUT + 1, 0);
        run_instr(6'b101011, 0, TIMEOUT + 1, 0);
        run_instr(6'b100011, 0, 0, 3);
        repeat (2) rst_cycle();
        run_instr(6'b000000, 0, 0, 0);

        for (int t = 0; t < 150; t++) begin
            k = $urandom_range(0, 6);
            if (k < 6) op = legal_ops[k];
            else begin
                do op = 6'($urandom_range(0, 63)); while (is_legal(op));
            end
            if ($urandom_range(0, 15) == 0) begin
                run_instr(op, -1, -1, $urandom_range(1, 3));
                repeat ($urandom_range(1, 2)) rst_cycle();
            end else begin
                run_instr(op, -1, -1, 0);
            end
        end

        // final report
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences a multicycle MIPS datapath: shared instruction/data memory, IR, A/B/ALUOut registers, PC.
- Replaces the single-cycle combinational control decoder; the existing ALU-control decoder still consumes alu_op.
- Issues per-state datapath enables and mux selects from the current opcode.
- Stalls on a memory ready handshake, with a watchdog on memory waits.

Parameters:
TIMEOUT, 15, max consecutive not-ready cycles in a memory state before abort (1..2^TO_W-1)
TO_W, 4, width of watchdog counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
opcode  input  6  instr[31:26] taken from IR (valid from DECODE onward)
zero  input  1  ALU zero flag (used only via pc_write_cond, passed through to datapath logic)
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if zero (beq)
iord  output  1  memory address: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR load
mem_to_reg  output  1  register write data: 0=ALUOut, 1=MDR
reg_dst  output  1  destination: 0=rt, 1=rd
reg_write  output  1  register file write
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
alu_op  output  2  00=add, 01=sub, 10=funct
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
state  output  4  current state code (debug)
illegal_op  output  1  one-cycle pulse: unsupported opcode in DECODE
mem_error  output  1  one-cycle pulse: watchdog abort

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable and go to FETCH.
- Reset (reset=0, async): state=FETCH, watchdog=0. While reset=0, every enable output and request is forced 0: pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, illegal_op, mem_error. All selects are 0 and state=0.
- Memory handshake:
  - In FETCH, MEMRD and MEMWR, mem_read/mem_write is held high every cycle.
  - The state advances only in a cycle with mem_ready=1.
  - In FETCH, ir_write and pc_write equal mem_ready, so PC+4 is committed only once.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. Goes to DECODE on mem_ready.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target). Next state by opcode:
  - 000000 -> EXEC
  - 100011 / 101011 -> MEMADR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - any other opcode -> FETCH, with illegal_op=1 for this cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD if opcode=100011, else MEMWR.
- MEMRD: iord=1, mem_read=1. Goes to MEMWB on mem_ready.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Goes to FETCH.
- MEMWR: iord=1, mem_write=1. Goes to FETCH on mem_ready.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Goes to FETCH.
- JUMP: pc_source=10, pc_write=1. Goes to FETCH.
- Latency with mem_ready always 1: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2.
- Watchdog:
  - Cleared on every state change.
  - Increments each cycle spent in FETCH/MEMRD/MEMWR with mem_ready=0.
  - If the counter equals TIMEOUT while mem_ready=0: mem_error=1 that cycle, request deasserted, next state=FETCH, counter cleared. An abort in FETCH re-fetches the same PC.
  - mem_ready=1 in the same cycle as the counter reaching TIMEOUT completes normally, with no error.
- Reset asserted mid-instruction aborts immediately. No partial register write occurs after reset rises.

Test Plan:
- Reset low 3 cycles, mem_ready=1 -> state=0, all enables 0. Release -> cycle 1 has mem_read=1, ir_write=1, pc_write=1.
- Opcode 000000, mem_ready=1 -> states 0,1,6,7,0. reg_write=1, reg_dst=1 only in state 7.
- Opcode 100011 with mem_ready low for 3 cycles in MEMRD -> state holds at 3, mem_read held high. Then MEMWB with mem_to_reg=1. Total 8 cycles.
- Opcode 000100 -> BRANCH with pc_write_cond=1, alu_op=01, pc_source=01. Opcode 000010 -> JUMP with pc_write=1, pc_source=10. Each takes 3 cycles.
- Opcode 111111 -> illegal_op pulses in DECODE, next state FETCH, no reg_write/mem_write.
- mem_ready held 0 in FETCH with TIMEOUT=15 -> mem_error pulses on the 16th wait cycle, pc_write never 1, fetch restarts.
